// File: rtl/nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider serving div/divu in the M stage.
// A start pulse in IDLE captures the operands. One PREP cycle forms the magnitudes,
// WIDTH ITER cycles produce the quotient one bit at a time, and one FIX cycle applies
// the signs and registers the results along with a one-cycle done pulse.
module nios2_qsys_0_div_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  input  logic             M_div_signed,
  input  logic             M_div_start,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_cell_result,
  output logic [WIDTH-1:0] M_div_remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;      // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0]  b_q, b_d;      // raw divisor, replaced by its magnitude in PREP
  logic              sgn_q, sgn_d;
  logic [WIDTH-1:0]  quo_q, quo_d;  // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]  rem_q, rem_d;  // partial remainder; it is always below the divisor,
                                    // so its top (WIDTH+1-th) bit is implicitly zero
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  remd_q, remd_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;

  // Next-state logic for the FSM and the datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    remd_d  = remd_q;
    done_d  = 1'b0;

    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};

    case (state_q)
      StIdle: begin
        if (M_div_start) begin
          a_d     = M_div_src1;
          b_d     = M_div_src2;
          sgn_d   = M_div_signed;
          state_d = StPrep;
        end
      end
      StPrep: begin
        quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_d     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        q_neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg_d = sgn_q & a_q[WIDTH-1];
        dz_d    = (b_q == '0);
        rem_d   = '0;
        cnt_d   = CntW'(WIDTH - 1);
        state_d = StIter;
      end
      StIter: begin
        // Borrow out of the trial subtract means the divisor did not fit: restore
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = shifted[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dz_q) begin
          res_d  = '1;
          remd_d = a_q;
        end else begin
          res_d  = q_neg_q ? -quo_q : quo_q;
          remd_d = r_neg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      remd_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      remd_q  <= remd_d;
      done_q  <= done_d;
    end
  end

  assign M_div_busy        = (state_q != StIdle);
  assign M_div_done        = done_q;
  assign M_div_cell_result = res_q;
  assign M_div_remainder   = remd_q;

endmodule
